// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares one pipelined RAM port between `requesters` clients. Each cycle at
//   most one request is granted (round-robin), registered onto the RAM port,
//   and tracked through a `pipelining`-deep tag pipeline so the response is
//   steered back to its owner exactly `pipelining` cycles after the transfer.
//
// Ports
//   clk, reset        clock (rising edge) / async active-low reset
//   req_valid/ready   per-requester handshake; ready is the one-hot grant
//   req_we/addr/wdata per-requester command, packed [i*W +: W]
//   resp_valid        one-hot response strobe
//   resp_error        out-of-bounds flag (qualified by resp_valid)
//   resp_rdata        read data for in-bounds reads, else 0
//   ram_addr/we/wdata registered RAM command
//   ram_rdata         RAM read data, valid `pipelining` cycles after issue
//   inflight          transactions issued but not yet responded
module ram_port_arbiter #(
    parameter int requesters = 4,
    parameter int word_size  = 8,
    parameter int word_count = 256,
    parameter int addr_width = 16,
    parameter int pipelining = 3
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [requesters-1:0]              req_valid,
    output logic [requesters-1:0]              req_ready,
    input  logic [requesters-1:0]              req_we,
    input  logic [requesters*addr_width-1:0]   req_addr,
    input  logic [requesters*word_size-1:0]    req_wdata,
    output logic [requesters-1:0]              resp_valid,
    output logic                               resp_error,
    output logic [word_size-1:0]               resp_rdata,
    output logic [$clog2(word_count)-1:0]      ram_addr,
    output logic                               ram_we,
    output logic [word_size-1:0]               ram_wdata,
    input  logic [word_size-1:0]               ram_rdata,
    output logic [$clog2(pipelining+1)-1:0]    inflight
);

    localparam int IDW = $clog2(requesters);
    localparam int RAW = $clog2(word_count);
    localparam int IFW = $clog2(pipelining+1);

    if (pipelining < 2 || pipelining > 4) begin : g_bad_pipelining
        $error("ram_port_arbiter: pipelining must be 2, 3 or 4");
    end

    typedef struct packed {
        logic [IDW-1:0] id;
        logic           we;
        logic           err;
    } txn_t;

    // ---------------- round-robin arbitration ----------------
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] gnt_id;
    logic           gnt_any;
    logic [IDW:0]   rr_idx;

    // Scan offsets from highest to lowest; the last hit wins, so the
    // requester closest to the pointer takes the grant.
    always_comb begin
        gnt_id  = ptr_q;
        gnt_any = 1'b0;
        rr_idx  = '0;
        for (int k = requesters-1; k >= 0; k--) begin
            rr_idx = {1'b0, ptr_q} + (IDW+1)'(k);
            if (rr_idx >= (IDW+1)'(requesters))
                rr_idx = rr_idx - (IDW+1)'(requesters);
            if (req_valid[rr_idx[IDW-1:0]]) begin
                gnt_id  = rr_idx[IDW-1:0];
                gnt_any = 1'b1;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (gnt_any && reset)
            req_ready[gnt_id] = 1'b1;
    end

    logic                  fire;
    logic [addr_width-1:0] sel_addr;
    logic [word_size-1:0]  sel_wdata;
    logic                  sel_we;
    logic                  oob;

    assign fire      = |(req_valid & req_ready);
    assign sel_addr  = req_addr[gnt_id*addr_width +: addr_width];
    assign sel_wdata = req_wdata[gnt_id*word_size +: word_size];
    assign sel_we    = req_we[gnt_id];
    assign oob       = |sel_addr[addr_width-1:RAW];

    always_comb begin
        ptr_d = ptr_q;
        if (fire)
            ptr_d = (gnt_id == IDW'(requesters-1)) ? '0 : gnt_id + 1'b1;
    end

    // ---------------- RAM command register ----------------
    logic [RAW-1:0]       ram_addr_q;
    logic                 ram_we_q;
    logic [word_size-1:0] ram_wdata_q;

    // Out-of-bounds transfers are turned into a harmless read of address 0;
    // idle cycles only drop the write enable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
        end else begin
            ram_we_q <= 1'b0;
            if (fire) begin
                ram_we_q    <= sel_we & ~oob;
                ram_addr_q  <= oob ? '0 : sel_addr[RAW-1:0];
                ram_wdata_q <= sel_wdata;
            end
        end
    end

    assign ram_addr  = ram_addr_q;
    assign ram_we    = ram_we_q;
    assign ram_wdata = ram_wdata_q;

    // ---------------- tag pipeline ----------------
    // Stage k holds the transaction transferred k cycles ago; the last stage
    // lines up with ram_rdata.
    logic [pipelining:1] vld_pipe_q;
    txn_t                txn_pipe_q [1:pipelining];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_pipe_q <= '0;
            for (int k = 1; k <= pipelining; k++)
                txn_pipe_q[k] <= '0;
        end else begin
            vld_pipe_q    <= {vld_pipe_q[pipelining-1:1], fire};
            txn_pipe_q[1] <= {gnt_id, sel_we, oob};
            for (int k = 2; k <= pipelining; k++)
                txn_pipe_q[k] <= txn_pipe_q[k-1];
        end
    end

    logic out_v;
    txn_t out_t;
    assign out_v = vld_pipe_q[pipelining];
    assign out_t = txn_pipe_q[pipelining];

    always_comb begin
        resp_valid = '0;
        resp_error = 1'b0;
        resp_rdata = '0;
        if (out_v) begin
            resp_valid[out_t.id] = 1'b1;
            resp_error           = out_t.err;
            if (!out_t.we && !out_t.err)
                resp_rdata = ram_rdata;
        end
    end

    // ---------------- state registers ----------------
    logic [IFW-1:0] inflight_q, inflight_d;

    always_comb begin
        inflight_d = inflight_q;
        case ({fire, out_v})
            2'b10:   inflight_d = inflight_q + IFW'(1);
            2'b01:   inflight_d = inflight_q - IFW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q      <= '0;
            inflight_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            inflight_q <= inflight_d;
        end
    end

    assign inflight = inflight_q;

endmodule
